// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command payload used by the master, decoder and slave mux.
package ahb_lite_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [2:0]        size;
   } cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Command FIFO: filled by a zero-time task from the bench side, drained by the bus clock.
module ahb_cmd_fifo
   import ahb_lite_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pop_i,
   output cmd_t                   head_o,
   output cmd_t                   next_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   cmd_t             mem [DEPTH];
   logic [CNT_W-1:0] wr_ptr = '0;
   logic [CNT_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] rd_ptr_d;
   logic [PTR_W-1:0] rd_idx;
   logic [PTR_W-1:0] nx_idx;

   // Fullness is computed inside the task so several calls in one time step see each other.
   task automatic push(input cmd_t cmd);
      if ((wr_ptr - rd_ptr_q) == CNT_W'(DEPTH)) begin
         $display("FIFO overflow");
      end else begin
         mem[wr_ptr[PTR_W-1:0]] = cmd;
         wr_ptr = wr_ptr + CNT_W'(1);
      end
   endtask

   always_comb begin
      rd_idx   = rd_ptr_q[PTR_W-1:0];
      nx_idx   = rd_idx + PTR_W'(1);
      head_o   = mem[rd_idx];
      next_o   = mem[nx_idx];
      count_o  = wr_ptr - rd_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
   end

   // Reset empties the queue by catching the read pointer up to the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= wr_ptr;
      end else begin
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/ahb_lite_master_task.sv
// Behavioural AHB-Lite master: queued commands issued as pipelined SINGLE transfers.
module ahb_lite_master_task
   import ahb_lite_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [31:0] HRDATA,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [1:0]  HTRANS,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   cmd_t             fifo_head;
   cmd_t             fifo_next;
   logic [CNT_W-1:0] fifo_count;
   logic             consumed_c;
   cmd_t             issue_c;

   logic [31:0]      haddr_q,      haddr_d;
   logic             hwrite_q,     hwrite_d;
   logic [2:0]       hsize_q,      hsize_d;
   logic [1:0]       htrans_q,     htrans_d;
   logic [31:0]      ap_data_q,    ap_data_d;
   logic             dp_valid_q,   dp_valid_d;
   logic             dp_write_q,   dp_write_d;
   logic [31:0]      dp_addr_q,    dp_addr_d;
   logic [31:0]      hwdata_q,     hwdata_d;
   logic [31:0]      last_rdata_q, last_rdata_d;
   logic [CNT_W-1:0] avail_q,      avail_d;

   ahb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .pop_i   (consumed_c),
      .head_o  (fifo_head),
      .next_o  (fifo_next),
      .count_o (fifo_count)
   );

   task automatic push_command(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] size);
      cmd_t cmd;
      cmd.wr   = wr;
      cmd.addr = addr;
      cmd.data = data;
      cmd.size = size;
      u_fifo.push(cmd);
   endtask

   // The command on the address phase stays at the FIFO head until the bus accepts it.
   always_comb begin
      consumed_c   = HREADY && (htrans_q == HTRANS_NONSEQ);
      issue_c      = consumed_c ? fifo_next : fifo_head;
      avail_d      = fifo_count;
      haddr_d      = haddr_q;
      hwrite_d     = hwrite_q;
      hsize_d      = hsize_q;
      htrans_d     = htrans_q;
      ap_data_d    = ap_data_q;
      dp_valid_d   = dp_valid_q;
      dp_write_d   = dp_write_q;
      dp_addr_d    = dp_addr_q;
      hwdata_d     = hwdata_q;
      last_rdata_d = last_rdata_q;
      if (HREADY) begin
         dp_valid_d = consumed_c;
         if (consumed_c) begin
            dp_write_d = hwrite_q;
            dp_addr_d  = haddr_q;
            if (hwrite_q) begin
               hwdata_d = ap_data_q;
            end
         end
         if (dp_valid_q && !dp_write_q) begin
            last_rdata_d = HRDATA;
         end
         if (avail_q > CNT_W'(consumed_c)) begin
            htrans_d  = HTRANS_NONSEQ;
            haddr_d   = issue_c.addr;
            hwrite_d  = issue_c.wr;
            hsize_d   = issue_c.size;
            ap_data_d = issue_c.data;
         end else begin
            htrans_d  = HTRANS_IDLE;
         end
      end else if (HRESP) begin
         htrans_d = HTRANS_IDLE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr_q      <= '0;
         hwrite_q     <= 1'b0;
         hsize_q      <= '0;
         htrans_q     <= HTRANS_IDLE;
         ap_data_q    <= '0;
         dp_valid_q   <= 1'b0;
         dp_write_q   <= 1'b0;
         dp_addr_q    <= '0;
         hwdata_q     <= '0;
         last_rdata_q <= '0;
      end else begin
         haddr_q      <= haddr_d;
         hwrite_q     <= hwrite_d;
         hsize_q      <= hsize_d;
         htrans_q     <= htrans_d;
         ap_data_q    <= ap_data_d;
         dp_valid_q   <= dp_valid_d;
         dp_write_q   <= dp_write_d;
         dp_addr_q    <= dp_addr_d;
         hwdata_q     <= hwdata_d;
         last_rdata_q <= last_rdata_d;
      end
   end

   // Falling-edge snapshot keeps pushes made right at a rising edge out of that edge's pop.
   always_ff @(negedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         avail_q <= '0;
      end else begin
         avail_q <= avail_d;
      end
   end

   always @(posedge HCLK) begin
      if (HRESETn && HREADY && dp_valid_q) begin
         if (HRESP) begin
            $display("ERROR at %08h", dp_addr_q);
         end else if (!dp_write_q) begin
            $display("read addr %08h data %08h", dp_addr_q, HRDATA);
         end
      end
   end

   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VAL;
   assign HTRANS    = htrans_q;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master_task.sv
// Scoreboard bench for ahb_lite_master_task with two pattern slaves and a scripted responder.
`timescale 1ns/1ps
module tb_ahb_lite_master_task;
   import ahb_lite_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;
   logic [31:0] HRDATA = 32'hDEADBEEF;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;

   always #5 HCLK = ~HCLK;

   ahb_lite_master_task #(.DEPTH(DEPTH), .HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
   } xfer_t;

   xfer_t       exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          err_cnt = 0;
   int          hold_cnt = 0;
   bit          stall = 0;
   bit          err_en = 0;
   bit          rand_waits = 0;
   logic [31:0] err_addr = 32'hFFFFFFFF;
   logic [31:0] wait_addr = 32'hFFFFFFFF;
   int          wait_n = 0;
   bit          slv_busy = 0;
   bit          cd_v = 0;
   xfer_t       cd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h required %08h", name, act, req);
      end
   endtask

   // HSEL0 for HADDR[31:16]==0, HSEL1 for 1; each slave returns a fixed pattern plus offset.
   function automatic logic [31:0] slave_rdata(input logic [31:0] a);
      return (a[31:16] == 16'h0000) ? (32'hCAFE0000 | {16'h0, a[15:0]})
                                    : (32'h0BEE0000 | {16'h0, a[15:0]});
   endfunction

   // Reference model: the FIFO holds every command not yet accepted by the bus.
   task automatic do_push(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] size);
      xfer_t x;
      x.wr = wr; x.addr = addr; x.data = data; x.size = size;
      if (exp_q.size() < DEPTH) exp_q.push_back(x);
      dut.push_command(wr, addr, data, size);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #2;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((exp_q.size() != 0 || cd_v || slv_busy) && k < 400) begin
         cyc(1);
         k++;
      end
      n_cmp++;
      if (k >= 400) begin
         n_fail++;
         $display("FAIL %s_drain: %0d transfers outstanding, required 0", name, exp_q.size());
      end
      cyc(3);
   endtask

   // Slave side: samples the bus on the falling edge, drives its response just after rising.
   initial begin : slave
      logic        s_ready, s_acc, s_wr, dp_wr, dp_err;
      logic [31:0] s_addr, dp_addr;
      int          left;
      dp_wr = 0; dp_err = 0; dp_addr = 0; left = 0;
      forever begin
         @(negedge HCLK);
         s_ready = HREADY;
         s_acc   = HREADY && (HTRANS == 2'b10);
         s_addr  = HADDR;
         s_wr    = HWRITE;
         @(posedge HCLK);
         #1;
         if (!HRESETn) begin
            slv_busy = 0; HREADY = 1; HRESP = 0; HRDATA = 32'hDEADBEEF;
            continue;
         end
         if (s_ready) begin
            slv_busy = s_acc;
            dp_addr  = s_addr;
            dp_wr    = s_wr;
            if (s_acc) begin
               dp_err = err_en && (s_addr == err_addr);
               if (dp_err) left = 1;
               else if (rand_waits) left = int'($urandom_range(0, 2));
               else left = (s_addr == wait_addr) ? wait_n : 0;
            end
         end
         HRDATA = 32'hDEADBEEF;
         HRESP  = 0;
         if (stall) begin
            HREADY = 0;
         end else if (slv_busy) begin
            HRESP = dp_err;
            if (left > 0) begin
               HREADY = 0;
               left--;
            end else begin
               HREADY = 1;
               if (!dp_wr) HRDATA = slave_rdata(dp_addr);
            end
         end else begin
            HREADY = 1;
         end
      end
   end

   // Monitor: pops the scoreboard when an address phase is accepted, checks data phases.
   initial begin : monitor
      logic        p_ready, p_resp, p_wr, rd_chk;
      logic [1:0]  p_trans;
      logic [2:0]  p_size;
      logic [31:0] p_addr, p_wdata, rd_exp;
      bit          p_valid;
      xfer_t       e;
      p_valid = 0; rd_chk = 0; rd_exp = 0;
      p_ready = 0; p_resp = 0; p_wr = 0; p_trans = 0; p_size = 0; p_addr = 0; p_wdata = 0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            p_valid = 0; cd_v = 0; rd_chk = 0;
            continue;
         end
         if (rd_chk) begin
            check("last_rdata", dut.last_rdata_q, rd_exp);
            rd_chk = 0;
         end
         if (p_valid && !p_ready && !p_resp) begin
            check("wait_hold_addr", HADDR, p_addr);
            check("wait_hold_ctrl", 32'({HTRANS, HWRITE, HSIZE}), 32'({p_trans, p_wr, p_size}));
            check("wait_hold_wdata", HWDATA, p_wdata);
         end
         if (p_valid && !p_ready && p_resp && p_trans == 2'b10) begin
            check("error_cancel_idle", 32'(HTRANS), 32'h0);
            err_cnt++;
         end
         if (cd_v && cd.wr) check("hwdata", HWDATA, cd.data);
         if (HADDR == 32'h2 && HTRANS == 2'b10 && HWDATA == 32'hFF) hold_cnt++;
         if (HREADY) begin
            if (cd_v && !cd.wr) begin
               rd_chk = 1;
               rd_exp = slave_rdata(cd.addr);
            end
            cd_v = 0;
            if (HTRANS == 2'b10) begin
               n_acc++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_nonseq: addr %08h issued, scoreboard empty", HADDR);
               end else begin
                  e = exp_q.pop_front();
                  check("haddr", HADDR, e.addr);
                  check("hwrite_hsize", 32'({HWRITE, HSIZE}), 32'({e.wr, e.size}));
                  check("hburst_hprot_lock", 32'({HBURST, HPROT, HMASTLOCK}), 32'h06);
                  cd   = e;
                  cd_v = 1;
               end
            end
         end
         p_valid = 1; p_ready = HREADY; p_resp = HRESP; p_trans = HTRANS;
         p_addr = HADDR; p_wr = HWRITE; p_size = HSIZE; p_wdata = HWDATA;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_haddr"}, HADDR, 32'h0);
      check({tag, "_hwdata"}, HWDATA, 32'h0);
      check({tag, "_htrans"}, 32'(HTRANS), 32'h0);
      check({tag, "_ctrl"}, 32'({HWRITE, HSIZE, HBURST, HMASTLOCK}), 32'h0);
      check({tag, "_hprot"}, 32'(HPROT), 32'h3);
   endtask

   initial begin : stim
      int n0;
      int npush;
      #12;
      check_reset_outputs("in_reset");
      #9;
      HRESETn = 1'b1;
      cyc(1);
      check_reset_outputs("after_reset");
      check("after_reset_last_rdata", dut.last_rdata_q, 32'h0);

      // Five back-to-back pushes; two wait states on the first write.
      wait_addr = 32'h1; wait_n = 2; hold_cnt = 0;
      do_push(1'b1, 32'h00000001, 32'h000000FF, HSIZE_HALF);
      do_push(1'b0, 32'h00000002, 32'h0,        HSIZE_WORD);
      do_push(1'b1, 32'h00000010, 32'h000000AA, HSIZE_BYTE);
      do_push(1'b0, 32'h00010004, 32'h0,        HSIZE_WORD);
      do_push(1'b1, 32'h00000005, 32'h000000BF, HSIZE_HALF);
      #5;
      check("latency_still_idle", 32'(HTRANS), 32'h0);
      cyc(1);
      check("latency_first_nonseq", 32'(HTRANS), 32'h2);
      check("latency_first_addr", HADDR, 32'h1);
      wait_drain("five_push");
      check("wait_state_hold_cycles", 32'(hold_cnt), 32'd3);
      wait_n = 0;

      do_push(1'b0, 32'h00000000, 32'h0, HSIZE_WORD);
      wait_drain("read_cafe");
      check("read_cafe_last_rdata", dut.last_rdata_q, 32'hCAFE0000);

      // Two-cycle ERROR with the next command already on the address phase.
      err_en = 1; err_addr = 32'h00010020; err_cnt = 0;
      do_push(1'b1, 32'h00010020, 32'h11111111, HSIZE_WORD);
      do_push(1'b1, 32'h00010024, 32'h22222222, HSIZE_WORD);
      do_push(1'b0, 32'h00010028, 32'h0,        HSIZE_WORD);
      wait_drain("error");
      check("error_cancel_seen", 32'(err_cnt), 32'd1);
      err_en = 0;

      // DEPTH+1 pushes while the bus is stalled.
      stall = 1;
      cyc(3);
      n0 = n_acc;
      for (int i = 0; i <= DEPTH; i++) begin
         do_push(i[0], 32'h00000100 + 32'(i * 4), $urandom, HSIZE_WORD);
      end
      cyc(4);
      check("stall_idle", 32'(HTRANS), 32'h0);
      stall = 0;
      wait_drain("overflow");
      check("overflow_issued", 32'(n_acc - n0), 32'(DEPTH));

      rand_waits = 1;
      for (int it = 0; it < 60; it++) begin
         cyc(int'($urandom_range(1, 4)));
         npush = int'($urandom_range(1, 3));
         for (int j = 0; j < npush; j++) begin
            do_push(1'($urandom_range(0, 1)),
                    {15'h0, 1'($urandom_range(0, 1)), 16'($urandom)},
                    $urandom, 3'($urandom_range(0, 2)));
         end
      end
      wait_drain("random");
      rand_waits = 0;

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
